el2_trace_sink: RTL



---
 rtl/el2_trace_sink.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/el2_trace_sink.sv
// Instruction-trace sink: buffers retirement packets in a small FIFO and streams them as 32-bit beats.
// Optional address compression (skip the ADDR beat on sequential PCs) is enabled by RV_TRACE_SINK_COMPRESS_EN.
module el2_trace_sink #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        trace_enable,
  input  logic        trace_rv_i_valid_ip,
  input  logic [31:0] trace_rv_i_insn_ip,
  input  logic [31:0] trace_rv_i_address_ip,
  input  logic        trace_rv_i_exception_ip,
  input  logic [4:0]  trace_rv_i_ecause_ip,
  input  logic        trace_rv_i_interrupt_ip,
  input  logic [31:0] trace_rv_i_tval_ip,
  output logic        tr_out_valid,
  output logic [31:0] tr_out_data,
  output logic        tr_out_last,
  input  logic        tr_out_ready,
  output logic        tr_fifo_full,
  output logic [15:0] tr_drop_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic [4:0]  ecause;
    logic        intr;
    logic [31:0] tval;
    logic        ovf;
    logic [15:0] snap;
    logic        omit;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_INSN, S_TVAL} state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  state_t        state, nx_state;
  logic          ovf_pend;
  logic          capture, push, drop, fire, pop, addr_omit;
  entry_t        wr_entry, head, head_nx, src;
  logic          nx_valid, nx_last;
  logic [31:0]   nx_data;

  function automatic logic has_tval(input entry_t e);
    return e.exc | e.intr;
  endfunction

  function automatic logic [31:0] hdr_word(input entry_t e);
    logic [1:0] nf;
    nf = 2'd1 + {1'b0, ~e.omit} + {1'b0, has_tval(e)};
    return {4'hA, e.exc, e.intr, e.ecause, e.omit, has_tval(e), e.ovf, nf, e.snap};
  endfunction

  function automatic state_t beat_after(input state_t s, input entry_t e);
    case (s)
      S_HDR:   return e.omit ? S_INSN : S_ADDR;
      S_ADDR:  return S_INSN;
      S_INSN:  return has_tval(e) ? S_TVAL : S_IDLE;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [31:0] beat_data(input state_t s, input entry_t e);
    case (s)
      S_HDR:   return hdr_word(e);
      S_ADDR:  return e.addr;
      S_INSN:  return e.insn;
      S_TVAL:  return e.tval;
      default: return 32'h0;
    endcase
  endfunction

  assign capture = trace_rv_i_valid_ip & trace_enable;
  assign push    = capture & ~tr_fifo_full;
  assign drop    = capture & tr_fifo_full;
  assign fire    = tr_out_valid & tr_out_ready;
  assign pop     = fire & tr_out_last;
  assign head    = mem[rd_ptr];
  assign head_nx = mem[rd_ptr + AW'(1)];
  assign count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef RV_TRACE_SINK_COMPRESS_EN
  logic [31:0] exp_addr;
  logic        exp_v;

  assign addr_omit = exp_v & (trace_rv_i_address_ip == exp_addr);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      exp_addr <= 32'h0;
      exp_v    <= 1'b0;
    end else if (push) begin
      exp_addr <= trace_rv_i_address_ip + ((trace_rv_i_insn_ip[1:0] == 2'b11) ? 32'd4 : 32'd2);
      exp_v    <= ~(trace_rv_i_exception_ip | trace_rv_i_interrupt_ip);
    end else if (drop) begin
      exp_v    <= 1'b0;
    end
  end
`else
  assign addr_omit = 1'b0;
`endif

  always_comb begin
    wr_entry        = '0;
    wr_entry.insn   = trace_rv_i_insn_ip;
    wr_entry.addr   = trace_rv_i_address_ip;
    wr_entry.exc    = trace_rv_i_exception_ip;
    wr_entry.ecause = trace_rv_i_ecause_ip;
    wr_entry.intr   = trace_rv_i_interrupt_ip;
    wr_entry.tval   = trace_rv_i_tval_ip;
    wr_entry.ovf    = ovf_pend;
    wr_entry.snap   = ovf_pend ? tr_drop_cnt : 16'h0;
    wr_entry.omit   = addr_omit;
  end

  // Next beat is chosen from the post-edge FIFO view so a push into an empty FIFO
  // (or a pop with nothing behind it) lands on the output without a bubble.
  always_comb begin
    nx_state = state;
    src      = head;
    case (state)
      S_IDLE: begin
        if (count != '0 || push) begin
          src      = (count != '0) ? head : wr_entry;
          nx_state = S_HDR;
        end
      end
      default: begin
        if (fire) begin
          if (tr_out_last) begin
            if (count > (AW+1)'(1)) begin
              src      = head_nx;
              nx_state = S_HDR;
            end else if (push) begin
              src      = wr_entry;
              nx_state = S_HDR;
            end else begin
              nx_state = S_IDLE;
            end
          end else begin
            nx_state = beat_after(state, head);
          end
        end
      end
    endcase
    nx_valid = tr_out_valid;
    nx_data  = tr_out_data;
    nx_last  = tr_out_last;
    if (fire || (state == S_IDLE && nx_state != S_IDLE)) begin
      nx_valid = (nx_state != S_IDLE);
      nx_data  = beat_data(nx_state, src);
      nx_last  = (nx_state == S_TVAL) || (nx_state == S_INSN && !has_tval(src));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l && push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tr_fifo_full <= 1'b0;
      tr_drop_cnt  <= 16'h0;
      ovf_pend     <= 1'b0;
      state        <= S_IDLE;
      tr_out_valid <= 1'b0;
      tr_out_data  <= 32'h0;
      tr_out_last  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nx;
      tr_fifo_full <= (count_nx == (AW+1)'(DEPTH));
      // The loss count travels with the first packet captured after the overflow.
      if (push && ovf_pend) begin
        tr_drop_cnt <= 16'h0;
        ovf_pend    <= 1'b0;
      end else if (drop) begin
        if (tr_drop_cnt != 16'hFFFF) tr_drop_cnt <= tr_drop_cnt + 16'd1;
        ovf_pend <= 1'b1;
      end
      state        <= nx_state;
      tr_out_valid <= nx_valid;
      tr_out_data  <= nx_data;
      tr_out_last  <= nx_last;
    end
  end

endmodule
